// File: rtl/dma_pkg.sv
// Shared types and fixed addresses for the sprite (OAM) DMA controller.
package dma_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to 4014 halts the CPU and copies page {P,00..ff} to 2004.
// Optional feature macro OAM_DMA_ALIGN_EN adds the parity-driven ALIGN dummy cycle.
module oam_dma
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    output logic        rdy,
    output logic        busy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw,
    input  logic [7:0]  bus_rdata
);

    dma_state_t r_state;
    dma_state_t w_state_nxt;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_buf;
    logic       w_trigger;

    assign w_trigger = (cpu_addr == OAM_DMA_ADDR) && !cpu_rw;

`ifdef OAM_DMA_ALIGN_EN
    // Free-running cycle parity; reads must start on the same phase every transfer.
    logic r_parity;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_parity <= 1'b0;
        else          r_parity <= ~r_parity;
    end
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= DMA_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Page is only loaded from IDLE, so retriggers during a transfer are ignored.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_page <= 8'h00;
            r_idx  <= 8'h00;
            r_buf  <= 8'h00;
        end else begin
            if (r_state == DMA_IDLE && w_trigger) begin
                r_page <= cpu_wdata;
                r_idx  <= 8'h00;
            end
            if (r_state == DMA_READ)  r_buf <= bus_rdata;
            if (r_state == DMA_WRITE) r_idx <= r_idx + 8'h01;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rdy         = (r_state == DMA_IDLE);
        busy        = (r_state != DMA_IDLE);
        bus_addr    = cpu_addr;
        bus_wdata   = cpu_wdata;
        bus_rw      = cpu_rw;
        case (r_state)
            DMA_IDLE: begin
                if (w_trigger) w_state_nxt = DMA_HALT;
            end
            DMA_HALT: begin
                // Only a CPU read cycle actually stalls the CPU.
                if (cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
                    w_state_nxt = r_parity ? DMA_ALIGN : DMA_READ;
`else
                    w_state_nxt = DMA_READ;
`endif
                end
            end
            DMA_ALIGN: begin
                bus_addr    = {r_page, r_idx};
                bus_wdata   = r_buf;
                bus_rw      = 1'b1;
                w_state_nxt = DMA_READ;
            end
            DMA_READ: begin
                bus_addr    = {r_page, r_idx};
                bus_wdata   = r_buf;
                bus_rw      = 1'b1;
                w_state_nxt = DMA_WRITE;
            end
            DMA_WRITE: begin
                bus_addr    = OAM_DATA_ADDR;
                bus_wdata   = r_buf;
                bus_rw      = 1'b0;
                w_state_nxt = (r_idx == 8'hff) ? DMA_IDLE : DMA_READ;
            end
            default: begin
                w_state_nxt = DMA_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: idle pass-through table, random idle traffic, and DMA transfers
// checked against a RAM/OAM model and cycle-count expectations from the bus rules.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic        rdy, busy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic [7:0]  bus_rdata;

    logic [7:0] ram [0:65535];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cnt;

    oam_dma dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw    (cpu_rw),
        .rdy       (rdy),
        .busy      (busy),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rw    (bus_rw),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    assign bus_rdata = ram[bus_addr];

    // Clock edges since reset release; the DMA parity equals cnt % 2.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) cnt <= 0;
        else          cnt <= cnt + 1;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        rw;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after the falling edge, sample 1 ns later, model the bus write.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = rw;
        #1;
        if (n_reset && bus_rw == 1'b0) begin
            if (bus_addr == 16'h2004) got_q.push_back(bus_wdata);
            else                      ram[bus_addr] = bus_wdata;
        end
    endtask

    task automatic check_pass(input string name);
        check({name, " rdy"}, rdy, 1);
        check({name, " busy"}, busy, 0);
        check({name, " addr"}, bus_addr, cpu_addr);
        check({name, " wdata"}, bus_wdata, cpu_wdata);
        check({name, " rw"}, bus_rw, cpu_rw);
    endtask

    task automatic run_dma(input logic [7:0] pg, input int want_par, input int n_wr,
                           input bit retrig, input int abort_at, input string tag);
        int c, low, exp_low, n;
        bit done;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(ram[{pg, i[7:0]}]);
        for (int k = 0; k < 3; k++)
            if (want_par >= 0 && ((cnt + 1) % 2) != want_par) step(16'hc000, 8'h00, 1'b1);
        step(16'h4014, pg, 1'b0);
        c = cnt;
        check({tag, " trig rdy"}, rdy, 1);
        for (int w = 0; w < n_wr; w++) begin
            step(16'h01fd - 16'(w), 8'h30 + 8'(w), 1'b0);
            check({tag, " halt rdy"}, rdy, 0);
            check({tag, " halt addr"}, bus_addr, cpu_addr);
            check({tag, " halt rw"}, bus_rw, 0);
            check({tag, " halt wdata"}, bus_wdata, cpu_wdata);
        end
        low  = n_wr;
        done = 1'b0;
        for (int t = 0; t < 1200 && !done; t++) begin
            if (retrig && got_q.size() >= 10 && got_q.size() < 30)
                step(16'h4014, 8'h07, 1'b0);
            else
                step(16'hc000, 8'h00, 1'b1);
            if (abort_at > 0 && got_q.size() == abort_at) begin
                n_reset = 1'b0;
                #1;
                check_pass({tag, " abort"});
                n = got_q.size();
                for (int i = 0; i < n; i++) check({tag, " abort byte"}, got_q[i], exp_q[i]);
                #1 n_reset = 1'b1;
                return;
            end
            if (rdy) done = 1'b1;
            else     low++;
        end
        check({tag, " finished"}, done, 1);
        check({tag, " end busy"}, busy, 0);
        exp_low = 513 + n_wr;
`ifdef OAM_DMA_ALIGN_EN
        exp_low += (c + 1 + n_wr) % 2;
`endif
        check({tag, " rdy low cycles"}, low, exp_low);
        check({tag, " write count"}, got_q.size(), 256);
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check($sformatf("%s byte %0d", tag, n), got_q.pop_front(), exp_q.pop_front());
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) ram[{8'h02, i[7:0]}] = i[7:0] ^ 8'ha5;

        // Reset state
        n_reset   = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h99;
        cpu_rw    = 1'b1;
        #1;
        check_pass("reset");
        @(negedge clk);
        n_reset = 1'b1;

        // Idle pass-through vectors; a read of 4014 must not trigger.
        vecs[0] = '{16'h0010, 8'h00, 1'b1};
        vecs[1] = '{16'h0011, 8'h5a, 1'b0};
        vecs[2] = '{16'hffff, 8'hff, 1'b1};
        vecs[3] = '{16'h4015, 8'h12, 1'b0};
        vecs[4] = '{16'h4014, 8'h33, 1'b1};
        vecs[5] = '{16'h2004, 8'h44, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].addr, vecs[i].wd, vecs[i].rw);
            check($sformatf("idle vec %0d", i), {bus_addr, bus_wdata, bus_rw, rdy, busy},
                  {vecs[i].addr, vecs[i].wd, vecs[i].rw, 1'b1, 1'b0});
        end
        check("idle ram 0011", ram[16'h0011], 8'h5a);

        // Random idle traffic
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            logic rw;
            a  = 16'($urandom_range(0, 65535));
            rw = 1'($urandom_range(0, 1));
            if (a == 16'h4014) rw = 1'b1;
            step(a, 8'($urandom_range(0, 255)), rw);
            check_pass("rand idle");
        end

        run_dma(8'h02, -1, 0, 1'b0, 0, "basic");
        run_dma(8'($urandom_range(3, 127)), 0, 0, 1'b0, 0, "even");
        run_dma(8'($urandom_range(3, 127)), 1, 0, 1'b0, 0, "odd");

        ram[16'h01fd] = 8'h00;
        ram[16'h01fc] = 8'h00;
        ram[16'h01fb] = 8'h00;
        run_dma(8'($urandom_range(3, 127)), -1, 3, 1'b0, 0, "halt_wr");
        check("push 01fd", ram[16'h01fd], 8'h30);
        check("push 01fc", ram[16'h01fc], 8'h31);
        check("push 01fb", ram[16'h01fb], 8'h32);

        run_dma(8'h02, -1, 0, 1'b1, 0, "retrig");

        run_dma(8'h05, -1, 0, 1'b0, 100, "abort");
        step(16'h0020, 8'h00, 1'b1);
        check_pass("after abort");
        run_dma(8'h06, -1, 0, 1'b0, 0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
